// File: rtl/bch15_pkg.sv
// Shared constants, GF(16) helpers and FSM encoding for the BCH(15,7) t=2 decoder.
// Latency: none (package only).
// Backpressure: n/a.
// Field is GF(2^4) with primitive polynomial x^4+x+1, alpha = 4'h2.
package bch15_pkg;

  localparam int N   = 15;
  localparam int K   = 7;
  localparam int GFW = 4;

  localparam logic [GFW-1:0] ALPHA  = 4'h2;
  localparam logic [GFW-1:0] ALPHA2 = 4'h4;
  localparam logic [GFW-1:0] ALPHA3 = 4'h8;

  // Shared bit / Chien position counter wraps after this value.
  localparam logic [3:0] CNT_LAST = 4'(N - 1);

  // Multiplicative inverse table, entry x holds inv(x); inv(0) is defined as 0
  // so that sigma2 collapses to 0 when S1 = 0.
  localparam logic [15:0][GFW-1:0] GF_INV = 64'h834A_5C2F_67BD_E910;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_CHIEN = 2'd2,
    ST_OUT   = 2'd3
  } state_e;

  function automatic logic [GFW-1:0] gf_inv(input logic [GFW-1:0] x);
    return GF_INV[x];
  endfunction

endpackage

// File: rtl/gf16_mul.sv
// GF(2^4) multiplier, product reduced modulo x^4+x+1.
// Latency: combinational.
// Backpressure: n/a.
// Ports: a_i, b_i operands; p_o 4-bit product.
module gf16_mul
  import bch15_pkg::*;
(
  input  logic [GFW-1:0] a_i,
  input  logic [GFW-1:0] b_i,
  output logic [GFW-1:0] p_o
);

  logic [2*GFW-2:0] prod;

  always_comb begin
    prod = '0;
    for (int i = 0; i < GFW; i++) begin
      if (b_i[i]) prod = prod ^ ({3'b000, a_i} << i);
    end
    // x^4 = x+1, x^5 = x^2+x, x^6 = x^3+x^2
    p_o = prod[3:0]
        ^ (prod[4] ? 4'h3 : 4'h0)
        ^ (prod[5] ? 4'h6 : 4'h0)
        ^ (prod[6] ? 4'hC : 4'h0);
  end

endmodule

// File: rtl/bch15_7_dec.sv
// Serial BCH(15,7) t=2 decoder: Horner syndromes, one-cycle locator, 15-cycle Chien search.
// Latency: out_vld rises 17 cycles after the edge that accepts the 15th bit.
// Backpressure: result held in OUT until out_rdy; in_rdy high only in IDLE.
// Ports: clk, rst_n (async low); in_vld/in_bit/in_rdy serial input (r14 first);
//        out_vld/out_rdy handshake; out_data[6]=r14, out_nerr 0..2, out_fail.
module bch15_7_dec
  import bch15_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_vld,
  input  logic         in_bit,
  output logic         in_rdy,
  output logic         out_vld,
  input  logic         out_rdy,
  output logic [K-1:0] out_data,
  output logic [1:0]   out_nerr,
  output logic         out_fail
);

  state_e           state_q;
  logic [3:0]       cnt_q;
  logic [GFW-1:0]   s1_q, s3_q, t1_q, t2_q;
  logic [N-1:0]     buf_q, flip_q;
  logic [1:0]       deg_q;
  logic             fail_q;
  logic [3:0]       nroot_q;
  logic             in_rdy_q, out_vld_q, out_fail_q;
  logic [K-1:0]     out_data_q;
  logic [1:0]       out_nerr_q;

  logic [GFW-1:0]   s1_a, s3_a3, s1_sq, s1_cu, sig2;
  logic [GFW-1:0]   s1_d, s3_d, t1_src, t2_src, t1_d, t2_d;
  logic [1:0]       deg_d;
  logic             fail_d, is_root, final_fail;
  logic [3:0]       pos;

  gf16_mul u_s1_step (.a_i(s1_q),          .b_i(ALPHA),        .p_o(s1_a));
  gf16_mul u_s3_step (.a_i(s3_q),          .b_i(ALPHA3),       .p_o(s3_a3));
  gf16_mul u_s1_sq   (.a_i(s1_q),          .b_i(s1_q),         .p_o(s1_sq));
  gf16_mul u_s1_cu   (.a_i(s1_sq),         .b_i(s1_q),         .p_o(s1_cu));
  gf16_mul u_sig2    (.a_i(s3_q ^ s1_cu),  .b_i(gf_inv(s1_q)), .p_o(sig2));
  gf16_mul u_t1_step (.a_i(t1_src),        .b_i(ALPHA),        .p_o(t1_d));
  gf16_mul u_t2_step (.a_i(t2_src),        .b_i(ALPHA2),       .p_o(t2_d));

  always_comb begin
    s1_d   = s1_a  ^ {3'b000, in_bit};
    s3_d   = s3_a3 ^ {3'b000, in_bit};
    // In CALC the step multipliers seed t1/t2 from sigma; in CHIEN they advance them.
    t1_src = (state_q == ST_CALC) ? s1_q : t1_q;
    t2_src = (state_q == ST_CALC) ? sig2 : t2_q;
    // sigma2 is already 0 when S3 = S1^3 (and when S1 = 0 via inv(0) = 0).
    deg_d  = 2'd0;
    if (s1_q != 4'h0) deg_d = (s3_q == s1_cu) ? 2'd1 : 2'd2;
    fail_d     = (s1_q == 4'h0) && (s3_q != 4'h0);
    is_root    = ((t1_q ^ t2_q) == 4'h1);
    pos        = CNT_LAST - cnt_q;
    final_fail = fail_q || (nroot_q != {2'b00, deg_q});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      s1_q       <= '0;
      s3_q       <= '0;
      t1_q       <= '0;
      t2_q       <= '0;
      buf_q      <= '0;
      flip_q     <= '0;
      deg_q      <= '0;
      fail_q     <= 1'b0;
      nroot_q    <= '0;
      in_rdy_q   <= 1'b1;
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      out_nerr_q <= '0;
      out_fail_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_vld && in_rdy_q) begin
            buf_q <= {buf_q[N-2:0], in_bit};
            s1_q  <= s1_d;
            s3_q  <= s3_d;
            if (cnt_q == CNT_LAST) begin
              cnt_q    <= '0;
              in_rdy_q <= 1'b0;
              state_q  <= ST_CALC;
            end else begin
              cnt_q <= cnt_q + 4'd1;
            end
          end
        end
        ST_CALC: begin
          t1_q    <= t1_d;
          t2_q    <= t2_d;
          deg_q   <= deg_d;
          fail_q  <= fail_d;
          nroot_q <= '0;
          flip_q  <= '0;
          state_q <= ST_CHIEN;
        end
        ST_CHIEN: begin
          t1_q <= t1_d;
          t2_q <= t2_d;
          if (is_root) begin
            flip_q  <= flip_q | (15'(1) << pos);
            nroot_q <= nroot_q + 4'd1;
          end
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            state_q <= ST_OUT;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        ST_OUT: begin
          // First OUT cycle resolves the root-count check and registers the result.
          if (!out_vld_q) begin
            out_vld_q  <= 1'b1;
            out_fail_q <= final_fail;
            out_nerr_q <= final_fail ? 2'd0 : deg_q;
            out_data_q <= final_fail ? buf_q[N-1:N-K] : (buf_q[N-1:N-K] ^ flip_q[N-1:N-K]);
          end else if (out_rdy) begin
            out_vld_q <= 1'b0;
            in_rdy_q  <= 1'b1;
            s1_q      <= '0;
            s3_q      <= '0;
            state_q   <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_rdy   = in_rdy_q;
  assign out_vld  = out_vld_q;
  assign out_data = out_data_q;
  assign out_nerr = out_nerr_q;
  assign out_fail = out_fail_q;

endmodule

// File: tb/tb_bch15_7_dec.sv
// Scoreboard bench for bch15_7_dec: directed codewords, gaps, back-pressure, mid-word reset.
// Latency: n/a.
// Backpressure: bench drives out_rdy, including a 5-cycle stall.
module tb_bch15_7_dec;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_vld, in_bit, in_rdy;
  logic       out_vld, out_rdy;
  logic [6:0] out_data;
  logic [1:0] out_nerr;
  logic       out_fail;

  typedef struct packed {
    logic [6:0] data;
    logic [1:0] nerr;
    logic       fail;
  } exp_t;

  typedef struct packed {
    logic [14:0] word;
    logic [6:0]  data;
    logic [1:0]  nerr;
    logic        fail;
  } vec_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Hand-derived vectors over GF(16), x^4+x+1.
  localparam int NV = 8;
  vec_t vecs [NV] = '{
    '{15'h40E8, 7'h40, 2'd0, 1'b0},  // clean codeword
    '{15'h00E8, 7'h40, 2'd1, 1'b0},  // bit 14 flipped
    '{15'h50E0, 7'h40, 2'd2, 1'b0},  // bits 12 and 3 flipped
    '{15'h7FFF, 7'h7F, 2'd0, 1'b0},  // all-ones codeword
    '{15'h0013, 7'h00, 2'd0, 1'b1},  // S1=0, S3!=0
    '{15'h40E9, 7'h40, 2'd1, 1'b0},  // bit 0 flipped
    '{15'h7000, 7'h74, 2'd2, 1'b0},  // 3 errors, locator has roots at 10 and 6
    '{15'h40E3, 7'h40, 2'd0, 1'b1}   // 3 errors, degree 2 with no roots
  };

  bch15_7_dec dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_vld   (in_vld),
    .in_bit   (in_bit),
    .in_rdy   (in_rdy),
    .out_vld  (out_vld),
    .out_rdy  (out_rdy),
    .out_data (out_data),
    .out_nerr (out_nerr),
    .out_fail (out_fail)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Returns just after the edge that accepts the last bit.
  task automatic send_word(input logic [14:0] w, input bit gaps, input bit push,
                           input logic [6:0] ed, input logic [1:0] en, input logic ef);
    exp_t e;
    int   g;
    int   guard;
    if (push) begin
      e.data = ed;
      e.nerr = en;
      e.fail = ef;
      exp_q.push_back(e);
    end
    for (int i = 14; i >= 0; i--) begin
      if (gaps) begin
        g = $urandom_range(0, 3);
        repeat (g) begin
          @(negedge clk);
          in_vld = 1'b0;
        end
      end
      @(negedge clk);
      in_vld = 1'b1;
      in_bit = w[i];
      guard  = 0;
      while (!in_rdy && guard < 200) begin
        @(negedge clk);
        guard++;
      end
      if (!in_rdy) chk("in_rdy_timeout", {31'd0, in_rdy}, 32'd1);
      @(posedge clk);
    end
  endtask

  task automatic idle_in();
    @(negedge clk);
    in_vld = 1'b0;
    in_bit = 1'b0;
  endtask

  task automatic wait_drain();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  // Monitor: pop and compare on every output handshake.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n && out_vld && out_rdy) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out", {31'd0, out_vld}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("res_data", {25'd0, out_data}, {25'd0, e.data});
          chk("res_nerr", {30'd0, out_nerr}, {30'd0, e.nerr});
          chk("res_fail", {31'd0, out_fail}, {31'd0, e.fail});
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n;
    int vld_seen;
    int guard;
    rst_n   = 1'b0;
    in_vld  = 1'b0;
    in_bit  = 1'b0;
    out_rdy = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_out_vld",  {31'd0, out_vld},  32'd0);
    chk("rst_out_data", {25'd0, out_data}, 32'd0);
    chk("rst_out_nerr", {30'd0, out_nerr}, 32'd0);
    chk("rst_out_fail", {31'd0, out_fail}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_rdy",   {31'd0, in_rdy},   32'd1);

    // Clean codeword with latency measurement
    send_word(vecs[0].word, 1'b0, 1'b1, vecs[0].data, vecs[0].nerr, vecs[0].fail);
    idle_in();
    n = 1;
    @(posedge clk);
    #1;
    while (!out_vld && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency", n, 17);
    wait_drain();

    // All vectors back-to-back, then again with random in_vld gaps
    for (int pass = 0; pass < 2; pass++) begin
      for (int v = 0; v < NV; v++)
        send_word(vecs[v].word, pass[0], 1'b1, vecs[v].data, vecs[v].nerr, vecs[v].fail);
      idle_in();
      wait_drain();
    end

    // Back-pressure: out_rdy low 5 cycles; in_vld junk during processing is ignored
    @(negedge clk);
    out_rdy = 1'b0;
    send_word(15'h50E0, 1'b0, 1'b1, 7'h40, 2'd2, 1'b0);
    @(negedge clk);
    in_vld = 1'b1;
    in_bit = 1'b1;
    guard  = 0;
    while (!out_vld && guard < 40) begin
      chk("busy_in_rdy", {31'd0, in_rdy}, 32'd0);
      @(negedge clk);
      guard++;
    end
    in_vld = 1'b0;
    in_bit = 1'b0;
    for (int c = 0; c < 5; c++) begin
      chk("stall_vld",  {31'd0, out_vld},  32'd1);
      chk("stall_rdy",  {31'd0, in_rdy},   32'd0);
      chk("stall_data", {25'd0, out_data}, 32'h40);
      chk("stall_nerr", {30'd0, out_nerr}, 32'd2);
      chk("stall_fail", {31'd0, out_fail}, 32'd0);
      @(negedge clk);
    end
    out_rdy = 1'b1;
    wait_drain();
    // The word after the stall must decode normally
    send_word(vecs[1].word, 1'b0, 1'b1, vecs[1].data, vecs[1].nerr, vecs[1].fail);
    idle_in();
    wait_drain();

    // Reset during CHIEN cycle 7 discards the word
    send_word(15'h40E8, 1'b0, 1'b0, 7'h00, 2'd0, 1'b0);
    idle_in();
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_in_rdy", {31'd0, in_rdy}, 32'd1);
    rst_n = 1'b1;
    vld_seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (out_vld) vld_seen++;
    end
    chk("no_spurious", vld_seen, 0);
    send_word(15'h40E8, 1'b0, 1'b1, 7'h40, 2'd0, 1'b0);
    idle_in();
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
